// File: rtl/idu_pkg.sv
// Shared types and constants for the rv64i instruction decode stage.
// Holds opcode/funct constants, the ALU opcode and special-instruction enums,
// enable bit indices and the packed decoded bundle carried through the stage.
package idu_pkg;

    localparam int IDU_ILEN = 32;
    localparam int IDU_XLEN = 64;
    localparam int IDU_RF   = 5;

    // Major opcodes
    localparam logic [6:0] OPC_RTY    = 7'h33;
    localparam logic [6:0] OPC_ITY    = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_ENV    = 7'h73;
    localparam logic [6:0] OPC_R64TY  = 7'h3B;
    localparam logic [6:0] OPC_I64TY  = 7'h1B;

    // funct7 values of register-register ops
    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Bit positions inside the 5-bit enable vector
    localparam int EN_RD     = 0;
    localparam int EN_RS1    = 1;
    localparam int EN_RS2    = 2;
    localparam int EN_MREAD  = 3;
    localparam int EN_MWRITE = 4;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_OR     = 5'd2,
        ALU_AND    = 5'd3,
        ALU_XOR    = 5'd4,
        ALU_SLL    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_SLT    = 5'd8,
        ALU_SLTU   = 5'd9,
        ALU_COPY_B = 5'd10,
        ALU_ADDW   = 5'd11,
        ALU_SUBW   = 5'd12,
        ALU_SLLW   = 5'd13,
        ALU_SRLW   = 5'd14,
        ALU_SRAW   = 5'd15,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19,
        ALU_DIV    = 5'd20,
        ALU_DIVU   = 5'd21,
        ALU_REM    = 5'd22,
        ALU_REMU   = 5'd23,
        ALU_MULW   = 5'd24,
        ALU_DIVW   = 5'd25,
        ALU_DIVUW  = 5'd26,
        ALU_REMW   = 5'd27,
        ALU_REMUW  = 5'd28
    } aluop_e;

    typedef enum logic [2:0] {
        SPEC_NONE  = 3'd0,
        SPEC_BR    = 3'd1,
        SPEC_JAL   = 3'd2,
        SPEC_JALR  = 3'd3,
        SPEC_AUIPC = 3'd4,
        SPEC_LUI   = 3'd5
    } specinst_e;

    typedef struct packed {
        logic [IDU_XLEN-1:0]   pc;
        logic [4:0]            enable;
        logic [3*IDU_RF-1:0]   regi;     // {rs2, rs1, rd}
        logic [2:0]            detail;
        aluop_e                aluop;
        specinst_e             specinst;
        logic [IDU_XLEN-1:0]   imm;
        logic                  illegal;
        logic [1:0]            env_exc;  // [0]=ecall, [1]=ebreak
    } idu_bundle_t;

    // 64-bit register/immediate ALU op from funct3; alt selects SUB/SRA.
    function automatic aluop_e alu_rr(input logic [2:0] f3, input logic alt);
        aluop_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // 32-bit word ALU op; only called for funct3 000/001/101.
    function automatic aluop_e alu_w(input logic [2:0] f3, input logic alt);
        aluop_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUBW : ALU_ADDW;
            3'b001:  op = ALU_SLLW;
            default: op = alt ? ALU_SRAW : ALU_SRLW;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/idu_pipe_dec_core.sv
// Combinational rv64i(+M) decoder: instruction word -> decoded bundle.
// Ports: inst_i/pc_i in, bundle_o out. Illegal encodings clear enables,
// specinst, ALU op and env exceptions so they cannot cause side effects.
module idu_pipe_dec_core
    import idu_pkg::*;
#(
    parameter int EN_M = 1
) (
    input  logic [IDU_ILEN-1:0] inst_i,
    input  logic [IDU_XLEN-1:0] pc_i,
    output idu_bundle_t         bundle_o
);

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [5:0]  f6;
    logic [11:0] f12;

    assign opcode = inst_i[6:0];
    assign rd     = inst_i[11:7];
    assign f3     = inst_i[14:12];
    assign rs1    = inst_i[19:15];
    assign rs2    = inst_i[24:20];
    assign f7     = inst_i[31:25];
    assign f6     = inst_i[31:26];
    assign f12    = inst_i[31:20];

    logic [IDU_XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt6, shamt5;

    assign imm_i  = {{(IDU_XLEN-12){inst_i[31]}}, inst_i[31:20]};
    assign imm_s  = {{(IDU_XLEN-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_b  = {{(IDU_XLEN-13){inst_i[31]}}, inst_i[31], inst_i[7],
                     inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u  = {{(IDU_XLEN-32){inst_i[31]}}, inst_i[31:12], 12'b0};
    assign imm_j  = {{(IDU_XLEN-21){inst_i[31]}}, inst_i[31], inst_i[19:12],
                     inst_i[20], inst_i[30:21], 1'b0};
    assign shamt6 = {{(IDU_XLEN-6){1'b0}}, inst_i[25:20]};
    assign shamt5 = {{(IDU_XLEN-5){1'b0}}, inst_i[24:20]};

    logic        ill;
    logic [4:0]  en;
    aluop_e      alu;
    specinst_e   spec;
    logic [IDU_XLEN-1:0] imm;
    logic [1:0]  env;

    always_comb begin
        ill  = 1'b0;
        en   = '0;
        alu  = ALU_ADD;
        spec = SPEC_NONE;
        imm  = '0;
        env  = '0;
        case (opcode)
            OPC_RTY: begin
                en[EN_RD] = 1'b1; en[EN_RS1] = 1'b1; en[EN_RS2] = 1'b1;
                if (f7 == F7_MULDIV && EN_M != 0) begin
                    // MUL..REMU follow funct3 order directly
                    alu = aluop_e'(ALU_MUL + {2'b00, f3});
                end else if (f7 == F7_BASE) begin
                    alu = alu_rr(f3, 1'b0);
                end else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) begin
                    alu = alu_rr(f3, 1'b1);
                end else begin
                    ill = 1'b1;
                end
            end
            OPC_R64TY: begin
                en[EN_RD] = 1'b1; en[EN_RS1] = 1'b1; en[EN_RS2] = 1'b1;
                if (f7 == F7_MULDIV && EN_M != 0) begin
                    case (f3)
                        3'b000:  alu = ALU_MULW;
                        3'b100:  alu = ALU_DIVW;
                        3'b101:  alu = ALU_DIVUW;
                        3'b110:  alu = ALU_REMW;
                        3'b111:  alu = ALU_REMUW;
                        default: ill = 1'b1;
                    endcase
                end else if (f7 == F7_BASE && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101)) begin
                    alu = alu_w(f3, 1'b0);
                end else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) begin
                    alu = alu_w(f3, 1'b1);
                end else begin
                    ill = 1'b1;
                end
            end
            OPC_ITY: begin
                en[EN_RD] = 1'b1; en[EN_RS1] = 1'b1;
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    // rv64 shifts carry a 6-bit shamt, so only funct6 is checked
                    imm = shamt6;
                    if (f6 != 6'h00 && f6 != 6'h10) ill = 1'b1;
                    alu = (f3 == 3'b001) ? ALU_SLL : (f6[4] ? ALU_SRA : ALU_SRL);
                end else begin
                    imm = imm_i;
                    alu = alu_rr(f3, 1'b0);
                end
            end
            OPC_I64TY: begin
                en[EN_RD] = 1'b1; en[EN_RS1] = 1'b1;
                case (f3)
                    3'b000: begin
                        imm = imm_i;
                        alu = ALU_ADDW;
                    end
                    3'b001, 3'b101: begin
                        imm = shamt5;
                        if (f7 != F7_BASE && f7 != F7_ALT) ill = 1'b1;
                        alu = (f3 == 3'b001) ? ALU_SLLW : (f7[5] ? ALU_SRAW : ALU_SRLW);
                    end
                    default: ill = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                en[EN_RD] = 1'b1; en[EN_RS1] = 1'b1; en[EN_MREAD] = 1'b1;
                imm = imm_i;
                if (f3 == 3'b111) ill = 1'b1;
            end
            OPC_STORE: begin
                en[EN_RS1] = 1'b1; en[EN_RS2] = 1'b1; en[EN_MWRITE] = 1'b1;
                imm = imm_s;
                if (f3[2]) ill = 1'b1;
            end
            OPC_BRANCH: begin
                en[EN_RS1] = 1'b1; en[EN_RS2] = 1'b1;
                imm  = imm_b;
                spec = SPEC_BR;
                case (f3)
                    F3_BEQ, F3_BNE:   alu = ALU_SUB;
                    F3_BLT, F3_BGE:   alu = ALU_SLT;
                    F3_BLTU, F3_BGEU: alu = ALU_SLTU;
                    default:          ill = 1'b1;
                endcase
            end
            OPC_JALR: begin
                en[EN_RD] = 1'b1; en[EN_RS1] = 1'b1;
                imm  = imm_i;
                spec = SPEC_JALR;
                if (f3 != 3'b000) ill = 1'b1;
            end
            OPC_JAL: begin
                en[EN_RD] = 1'b1;
                imm  = imm_j;
                spec = SPEC_JAL;
            end
            OPC_AUIPC: begin
                en[EN_RD] = 1'b1;
                imm  = imm_u;
                spec = SPEC_AUIPC;
            end
            OPC_LUI: begin
                en[EN_RD] = 1'b1;
                imm  = imm_u;
                spec = SPEC_LUI;
                alu  = ALU_COPY_B;
            end
            OPC_ENV: begin
                if (f12 > 12'd1 || rd != '0 || rs1 != '0 || f3 != '0) ill = 1'b1;
                else env = f12[0] ? 2'b10 : 2'b01;
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            en   = '0;
            alu  = ALU_ADD;
            spec = SPEC_NONE;
            env  = '0;
        end
    end

    always_comb begin
        bundle_o          = '0;
        bundle_o.pc       = pc_i;
        bundle_o.enable   = en;
        bundle_o.regi     = {rs2, rs1, rd};
        bundle_o.detail   = f3;
        bundle_o.aluop    = alu;
        bundle_o.specinst = spec;
        bundle_o.imm      = imm;
        bundle_o.illegal  = ill;
        bundle_o.env_exc  = env;
    end

endmodule

// File: rtl/idu_pipe.sv
// Registered decode stage: fetch handshake in, decoded bundle out one cycle later.
// Ports: clk/rst/flush, in_valid/ready + inst/pc, out_valid/ready + decoded fields.
// 2-entry skid buffer: in_ready_o is registered (!skid valid); flush drops everything.
module idu_pipe
    import idu_pkg::*;
#(
    parameter int INST_WIDTH = 32,
    parameter int XLEN       = 64,
    parameter int RF_SIZE    = 5,
    parameter int EN_M       = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [INST_WIDTH-1:0]  inst_i,
    input  logic [XLEN-1:0]        pc_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [XLEN-1:0]        pc_o,
    output logic [4:0]             enable_o,
    output logic [3*RF_SIZE-1:0]   regi_o,
    output logic [2:0]             detail_o,
    output logic [4:0]             aluop_o,
    output logic [2:0]             specinst_o,
    output logic [XLEN-1:0]        imm_o,
    output logic                   illegal_o,
    output logic [1:0]             env_exception_o
);

    idu_bundle_t dec_b;

    idu_pipe_dec_core #(
        .EN_M (EN_M)
    ) u_dec (
        .inst_i   (inst_i),
        .pc_i     (pc_i),
        .bundle_o (dec_b)
    );

    idu_bundle_t out_q, out_d, skid_q, skid_d;
    logic        out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
    logic        accept, out_free;

    assign accept   = in_valid_i & ~skid_vld_q;
    // Output entry can take new data when empty or being consumed this cycle
    assign out_free = ~out_vld_q | out_ready_i;

    always_comb begin
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (flush_i) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (out_free) begin
            if (skid_vld_q) begin
                // Skid holds the older instruction; no accept possible this cycle
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                out_d     = dec_b;
                out_vld_d = 1'b1;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (accept) begin
            skid_d     = dec_b;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q      <= '0;
            skid_q     <= '0;
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            skid_q     <= skid_d;
            out_vld_q  <= out_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign in_ready_o      = ~skid_vld_q;
    assign out_valid_o     = out_vld_q;
    assign pc_o            = out_q.pc;
    assign enable_o        = out_q.enable;
    assign regi_o          = out_q.regi;
    assign detail_o        = out_q.detail;
    assign aluop_o         = out_q.aluop;
    assign specinst_o      = out_q.specinst;
    assign imm_o           = out_q.imm;
    assign illegal_o       = out_q.illegal;
    assign env_exception_o = out_q.env_exc;

endmodule

// File: tb/tb_idu_pipe.sv
// Directed bench for idu_pipe: decode vectors, skid backpressure, flush, async reset.
// Two instances share stimulus: EN_M=1 (main) and EN_M=0 (M extension disabled).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_idu_pipe;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic [31:0] inst_i = '0;
    logic [63:0] pc_i = '0;
    logic        out_ready_i = 1'b1;

    logic        in_ready_o, out_valid_o, illegal_o;
    logic [63:0] pc_o, imm_o;
    logic [4:0]  enable_o, aluop_o;
    logic [14:0] regi_o;
    logic [2:0]  detail_o, specinst_o;
    logic [1:0]  env_exception_o;

    logic        nm_in_ready, nm_out_valid, nm_illegal;
    logic [63:0] nm_pc, nm_imm;
    logic [4:0]  nm_enable, nm_aluop;
    logic [14:0] nm_regi;
    logic [2:0]  nm_detail, nm_specinst;
    logic [1:0]  nm_env;

    always #5 clk_i = ~clk_i;

    idu_pipe #(.INST_WIDTH(32), .XLEN(64), .RF_SIZE(5), .EN_M(1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .inst_i(inst_i), .pc_i(pc_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .pc_o(pc_o), .enable_o(enable_o), .regi_o(regi_o), .detail_o(detail_o),
        .aluop_o(aluop_o), .specinst_o(specinst_o), .imm_o(imm_o),
        .illegal_o(illegal_o), .env_exception_o(env_exception_o)
    );

    idu_pipe #(.INST_WIDTH(32), .XLEN(64), .RF_SIZE(5), .EN_M(0)) dut_nm (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(nm_in_ready),
        .inst_i(inst_i), .pc_i(pc_i),
        .out_valid_o(nm_out_valid), .out_ready_i(out_ready_i),
        .pc_o(nm_pc), .enable_o(nm_enable), .regi_o(nm_regi), .detail_o(nm_detail),
        .aluop_o(nm_aluop), .specinst_o(nm_specinst), .imm_o(nm_imm),
        .illegal_o(nm_illegal), .env_exception_o(nm_env)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] inst;
        logic [63:0] imm;
        logic [4:0]  alu;
        logic [4:0]  en;
        logic [2:0]  spec;
        logic        ill;
        logic [1:0]  env;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [31:0] inst, input logic [63:0] imm,
                           input logic [4:0] alu, input logic [4:0] en,
                           input logic [2:0] spec, input logic ill, input logic [1:0] env);
        vec_t v;
        v.inst = inst; v.imm = imm; v.alu = alu; v.en = en;
        v.spec = spec; v.ill = ill; v.env = env;
        vecs.push_back(v);
    endtask

    // Offer one instruction for a single cycle; outputs are observed at the next falling edge.
    task automatic offer(input logic [31:0] inst, input logic [63:0] pc);
        in_valid_i = 1'b1;
        inst_i     = inst;
        pc_i       = pc;
        @(negedge clk_i);
        in_valid_i = 1'b0;
    endtask

    initial begin
        vec_t        v;
        logic [63:0] pcv;

        //         inst          imm                      alu    en        spec ill env
        add_vec(32'h002081B3, 64'h0,                  5'd0,  5'b00111, 3'd0, 0, 2'b00); // add x3,x1,x2
        add_vec(32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0,  5'b00011, 3'd0, 0, 2'b00); // addi x1,x0,-1
        add_vec(32'h027302B3, 64'h0,                  5'd16, 5'b00111, 3'd0, 0, 2'b00); // mul x5,x6,x7
        add_vec(32'h00208463, 64'h8,                  5'd1,  5'b00110, 3'd1, 0, 2'b00); // beq x1,x2,+8
        add_vec(32'h123452B7, 64'h1234_5000,          5'd10, 5'b00001, 3'd5, 0, 2'b00); // lui x5,0x12345
        add_vec(32'h0020B423, 64'h8,                  5'd0,  5'b10110, 3'd0, 0, 2'b00); // sd x2,8(x1)
        add_vec(32'h0020C423, 64'h0,                  5'd0,  5'b00000, 3'd0, 1, 2'b00); // store funct3=100
        add_vec(32'h43F0D093, 64'd63,                 5'd7,  5'b00011, 3'd0, 0, 2'b00); // srai x1,x1,63
        add_vec(32'hFFDFF0EF, 64'hFFFF_FFFF_FFFF_FFFC, 5'd0,  5'b00001, 3'd2, 0, 2'b00); // jal x1,-4
        add_vec(32'h00100073, 64'h0,                  5'd0,  5'b00000, 3'd0, 0, 2'b10); // ebreak
        add_vec(32'h00000073, 64'h0,                  5'd0,  5'b00000, 3'd0, 0, 2'b01); // ecall
        add_vec(32'h00200073, 64'h0,                  5'd0,  5'b00000, 3'd0, 1, 2'b00); // funct12=2
        add_vec(32'h0020A1B3 | 32'h4000_0000, 64'h0,  5'd0,  5'b00000, 3'd0, 1, 2'b00); // funct7=0x20, slt

        // Reset state
        #1 rst_ni = 1'b0;
        #2;
        chk("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready_o}, 64'd1);
        chk("rst_pc", pc_o, 64'd0);
        chk("rst_imm", imm_o, 64'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("idle_out_valid", {63'd0, out_valid_o}, 64'd0);

        // Decode vectors, downstream always ready
        out_ready_i = 1'b1;
        foreach (vecs[i]) begin
            v   = vecs[i];
            pcv = 64'h8000_0000_0000_0000 + 64'(i) * 64'd4;
            offer(v.inst, pcv);
            chk($sformatf("v%0d_valid", i), {63'd0, out_valid_o}, 64'd1);
            chk($sformatf("v%0d_pc", i), pc_o, pcv);
            chk($sformatf("v%0d_illegal", i), {63'd0, illegal_o}, {63'd0, v.ill});
            chk($sformatf("v%0d_enable", i), {59'd0, enable_o}, {59'd0, v.en});
            chk($sformatf("v%0d_specinst", i), {61'd0, specinst_o}, {61'd0, v.spec});
            chk($sformatf("v%0d_aluop", i), {59'd0, aluop_o}, {59'd0, v.alu});
            chk($sformatf("v%0d_env", i), {62'd0, env_exception_o}, {62'd0, v.env});
            chk($sformatf("v%0d_regi", i), {49'd0, regi_o},
                {49'd0, v.inst[24:20], v.inst[19:15], v.inst[11:7]});
            chk($sformatf("v%0d_detail", i), {61'd0, detail_o}, {61'd0, v.inst[14:12]});
            if (!v.ill) chk($sformatf("v%0d_imm", i), imm_o, v.imm);
            if (v.inst == 32'h027302B3) begin
                chk("nm_mul_illegal", {63'd0, nm_illegal}, 64'd1);
                chk("nm_mul_enable", {59'd0, nm_enable}, 64'd0);
            end
            if (v.inst == 32'h002081B3) begin
                chk("nm_add_illegal", {63'd0, nm_illegal}, 64'd0);
                chk("nm_add_enable", {59'd0, nm_enable}, 64'd7);
            end
        end
        @(negedge clk_i);
        chk("drained_valid", {63'd0, out_valid_o}, 64'd0);

        // Backpressure: A, B accepted then C blocked for 3 stalled cycles
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; inst_i = 32'h002081B3; pc_i = 64'hA0;
        @(negedge clk_i);
        chk("bp1_pc", pc_o, 64'hA0);
        chk("bp1_in_ready", {63'd0, in_ready_o}, 64'd1);
        inst_i = 32'hFFF00093; pc_i = 64'hB0;
        @(negedge clk_i);
        chk("bp2_pc", pc_o, 64'hA0);
        chk("bp2_in_ready", {63'd0, in_ready_o}, 64'd0);
        inst_i = 32'h123452B7; pc_i = 64'hC0;
        @(negedge clk_i);
        chk("bp3_pc_held", pc_o, 64'hA0);
        chk("bp3_imm_held", imm_o, 64'd0);
        chk("bp3_in_ready", {63'd0, in_ready_o}, 64'd0);
        out_ready_i = 1'b1;
        @(negedge clk_i);
        chk("rel1_pc", pc_o, 64'hB0);
        chk("rel1_imm", imm_o, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rel1_in_ready", {63'd0, in_ready_o}, 64'd1);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        chk("rel2_pc", pc_o, 64'hC0);
        chk("rel2_valid", {63'd0, out_valid_o}, 64'd1);
        @(negedge clk_i);
        chk("rel3_valid", {63'd0, out_valid_o}, 64'd0);

        // Flush with both entries full and a new instruction offered
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; inst_i = 32'h002081B3; pc_i = 64'hD0;
        @(negedge clk_i);
        pc_i = 64'hD4;
        @(negedge clk_i);
        chk("fl_full_in_ready", {63'd0, in_ready_o}, 64'd0);
        pc_i = 64'hD8; flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0; in_valid_i = 1'b0;
        chk("fl_valid", {63'd0, out_valid_o}, 64'd0);
        chk("fl_in_ready", {63'd0, in_ready_o}, 64'd1);
        out_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            chk($sformatf("fl_quiet%0d", k), {63'd0, out_valid_o}, 64'd0);
        end

        // Flush overrides a simultaneous accept into an empty stage
        in_valid_i = 1'b1; pc_i = 64'hE0; flush_i = 1'b1;
        @(negedge clk_i);
        in_valid_i = 1'b0; flush_i = 1'b0;
        chk("fl_acc_valid", {63'd0, out_valid_o}, 64'd0);

        // Asynchronous reset in the middle of a stall
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; inst_i = 32'h123452B7; pc_i = 64'hF0;
        @(negedge clk_i);
        pc_i = 64'hF4;
        @(negedge clk_i);
        in_valid_i = 1'b0;
        chk("rs_pre_imm", imm_o, 64'h1234_5000);
        #2 rst_ni = 1'b0;
        #1;
        chk("rs_valid", {63'd0, out_valid_o}, 64'd0);
        chk("rs_pc", pc_o, 64'd0);
        chk("rs_imm", imm_o, 64'd0);
        chk("rs_enable", {59'd0, enable_o}, 64'd0);
        chk("rs_spec", {61'd0, specinst_o}, 64'd0);
        chk("rs_in_ready", {63'd0, in_ready_o}, 64'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        out_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("rs_post_valid", {63'd0, out_valid_o}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
